// File: rtl/ddr_sps_dram_pkg.sv
// Shared definitions for the SPS DRAM controller.
// Holds the controller state encoding, the default refresh timing
// constants and a counter-width helper used by the controller and
// the refresh timer.
package ddr_sps_dram_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WRITE   = 3'd1,
        READ    = 3'd2,
        CAPTURE = 3'd3,
        REFRESH = 3'd4
    } state_e;

    localparam int unsigned DEFAULT_REFRESH_INTERVAL = 64;
    localparam int unsigned DEFAULT_REFRESH_CYCLES   = 2;

    // Bits needed to hold the values 0..n-1 (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ddr_sps_dram_controller_if.sv
// Host-side request/response bundle of the SPS DRAM controller.
//   ReqValid/ReqReady : request handshake, accepted when both are high
//   ReqWrite          : 1 = write, 0 = read
//   ReqAddress/ReqData: target word and write data
//   RespValid/RespData: one-cycle read response strobe and data
// master = host side, slave = controller side.
interface ddr_sps_dram_controller_if #(
    parameter int unsigned ADDR_WIDTH = 1,
    parameter int unsigned DATA_WIDTH = 1
);
    logic                  ReqValid;
    logic                  ReqReady;
    logic                  ReqWrite;
    logic [ADDR_WIDTH-1:0] ReqAddress;
    logic [DATA_WIDTH-1:0] ReqData;
    logic                  RespValid;
    logic [DATA_WIDTH-1:0] RespData;

    modport master (
        output ReqValid, ReqWrite, ReqAddress, ReqData,
        input  ReqReady, RespValid, RespData
    );

    modport slave (
        input  ReqValid, ReqWrite, ReqAddress, ReqData,
        output ReqReady, RespValid, RespData
    );
endinterface

// File: rtl/ddr_sps_refresh_timer.sv
// Refresh request source for the SPS DRAM controller.
// With DDR_SPS_DRAM_CTRL_AUTOREFRESH_EN defined a free-running counter
// (0..REFRESH_INTERVAL-1) raises a refresh event on each wrap and the
// refresh_req input is ignored; otherwise the event is a rising edge of
// refresh_req, found by comparing against a registered copy.
// Ports:
//   Clock, Reset          : clock, async active-high reset
//   refresh_req           : external refresh request (edge-detected)
//   refresh_start         : controller is starting a refresh burst
//   refresh_pending       : registered pending flag
//   refresh_pending_next_c: combinational next value of the pending flag
//   refresh_missed        : sticky, set when an event finds pending set
module ddr_sps_refresh_timer
    import ddr_sps_dram_pkg::*;
#(
    parameter int unsigned REFRESH_INTERVAL = DEFAULT_REFRESH_INTERVAL
) (
    input  logic Clock,
    input  logic Reset,
    input  logic refresh_req,
    input  logic refresh_start,
    output logic refresh_pending,
    output logic refresh_pending_next_c,
    output logic refresh_missed
);

    logic pending_q, pending_d;
    logic missed_q,  missed_d;
    logic refresh_event;

`ifdef DDR_SPS_DRAM_CTRL_AUTOREFRESH_EN
    localparam int unsigned TW = cnt_width(REFRESH_INTERVAL);

    logic [TW-1:0] timer_q, timer_d;
    logic          unused_refresh_req;

    assign unused_refresh_req = refresh_req;

    // Interval counter; the wrap is the refresh event.
    always_comb begin
        timer_d       = timer_q + TW'(1);
        refresh_event = 1'b0;
        if (timer_q == TW'(REFRESH_INTERVAL - 1)) begin
            timer_d       = '0;
            refresh_event = 1'b1;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end
`else
    localparam int unsigned unused_refresh_interval = REFRESH_INTERVAL;

    logic req_q, req_d;

    // Rising edge of the external request.
    always_comb begin
        req_d         = refresh_req;
        refresh_event = refresh_req && !req_q;
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            req_q <= 1'b0;
        end else begin
            req_q <= req_d;
        end
    end
`endif

    // Single pending flag; an event that finds an unserviced request
    // is recorded as missed rather than queued. A new event in the
    // cycle the old one is taken simply becomes the next pending one.
    always_comb begin
        pending_d = pending_q;
        missed_d  = missed_q;
        if (refresh_start) begin
            pending_d = 1'b0;
        end
        if (refresh_event) begin
            if (pending_q && !refresh_start) begin
                missed_d = 1'b1;
            end
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            pending_q <= 1'b0;
            missed_q  <= 1'b0;
        end else begin
            pending_q <= pending_d;
            missed_q  <= missed_d;
        end
    end

    assign refresh_pending        = pending_q;
    assign refresh_pending_next_c = pending_d;
    assign refresh_missed         = missed_q;

endmodule

// File: rtl/ddr_sps_dram_controller.sv
// SPS DRAM controller: serialises host reads/writes into single-cycle
// DRAM commands, inserts refresh bursts and returns read data on a
// one-cycle response strobe.
// Optional feature macro: DDR_SPS_DRAM_CTRL_AUTOREFRESH_EN selects the
// internal refresh timer instead of the external RefreshReq input.
// Ports:
//   Clock, Reset    : clock, async active-high reset
//   host            : request/response bundle (slave side)
//   RefreshReq      : external refresh request (without the macro)
//   RefreshMissed   : sticky missed-refresh flag
//   Address         : DRAM address (holds last value)
//   Enable/Read/Write/Refresh : DRAM command lines
//   DataOut, DataOutEnable    : write data and its tristate enable
//   DataIn          : DRAM data bus as sampled
// All outputs are registered; each is computed from the next state so
// it lines up with the state that drives it.
module ddr_sps_dram_controller
    import ddr_sps_dram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH       = 1,
    parameter int unsigned DATA_WIDTH       = 1,
    parameter int unsigned REFRESH_INTERVAL = DEFAULT_REFRESH_INTERVAL,
    parameter int unsigned REFRESH_CYCLES   = DEFAULT_REFRESH_CYCLES
) (
    input  logic                   Clock,
    input  logic                   Reset,
    ddr_sps_dram_controller_if.slave host,
    input  logic                   RefreshReq,
    output logic                   RefreshMissed,
    output logic [ADDR_WIDTH-1:0]  Address,
    output logic                   Enable,
    output logic                   Read,
    output logic                   Write,
    output logic                   Refresh,
    output logic [DATA_WIDTH-1:0]  DataOut,
    output logic                   DataOutEnable,
    input  logic [DATA_WIDTH-1:0]  DataIn
);

    localparam int unsigned CW = cnt_width(REFRESH_CYCLES);

    state_e                state_q, state_d;
    logic [CW-1:0]         rcnt_q, rcnt_d;
    logic                  ready_q, ready_d;
    logic                  enable_q, enable_d;
    logic                  read_q, read_d;
    logic                  write_q, write_d;
    logic                  refresh_q, refresh_d;
    logic                  doe_q, doe_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;

    logic refresh_pending;
    logic refresh_pending_next_c;
    logic refresh_start_c;
    logic accept_c;

    // Refresh wins over a simultaneous request: ready_q is already low
    // whenever a refresh is pending in IDLE.
    assign refresh_start_c = (state_q == IDLE) && refresh_pending;
    assign accept_c        = host.ReqValid && ready_q;

    ddr_sps_refresh_timer #(
        .REFRESH_INTERVAL (REFRESH_INTERVAL)
    ) u_refresh_timer (
        .Clock                  (Clock),
        .Reset                  (Reset),
        .refresh_req            (RefreshReq),
        .refresh_start          (refresh_start_c),
        .refresh_pending        (refresh_pending),
        .refresh_pending_next_c (refresh_pending_next_c),
        .refresh_missed         (RefreshMissed)
    );

    // Next state, request capture and registered output values.
    always_comb begin
        state_d      = state_q;
        rcnt_d       = rcnt_q;
        addr_d       = addr_q;
        dout_d       = '0;
        resp_valid_d = 1'b0;
        resp_data_d  = resp_data_q;

        case (state_q)
            IDLE: begin
                if (refresh_pending) begin
                    state_d = REFRESH;
                    rcnt_d  = CW'(REFRESH_CYCLES - 1);
                end else if (accept_c) begin
                    addr_d = host.ReqAddress;
                    if (host.ReqWrite) begin
                        state_d = WRITE;
                        dout_d  = host.ReqData;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            WRITE: begin
                state_d = IDLE;
            end
            READ: begin
                // DataIn is sampled at the end of the Read cycle.
                state_d      = CAPTURE;
                resp_valid_d = 1'b1;
                resp_data_d  = DataIn;
            end
            CAPTURE: begin
                state_d = IDLE;
            end
            REFRESH: begin
                if (rcnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    rcnt_d = rcnt_q - CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        enable_d  = (state_d == WRITE) || (state_d == READ);
        write_d   = (state_d == WRITE);
        read_d    = (state_d == READ);
        doe_d     = (state_d == WRITE);
        refresh_d = (state_d == REFRESH);
        ready_d   = (state_d == IDLE) && !refresh_pending_next_c;
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q      <= IDLE;
            rcnt_q       <= '0;
            ready_q      <= 1'b0;
            enable_q     <= 1'b0;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            refresh_q    <= 1'b0;
            doe_q        <= 1'b0;
            addr_q       <= '0;
            dout_q       <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            rcnt_q       <= rcnt_d;
            ready_q      <= ready_d;
            enable_q     <= enable_d;
            read_q       <= read_d;
            write_q      <= write_d;
            refresh_q    <= refresh_d;
            doe_q        <= doe_d;
            addr_q       <= addr_d;
            dout_q       <= dout_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
        end
    end

    assign host.ReqReady  = ready_q;
    assign host.RespValid = resp_valid_q;
    assign host.RespData  = resp_data_q;
    assign Address        = addr_q;
    assign Enable         = enable_q;
    assign Read           = read_q;
    assign Write          = write_q;
    assign Refresh        = refresh_q;
    assign DataOut        = dout_q;
    assign DataOutEnable  = doe_q;

endmodule
